// File: rtl/io_trap_capture.sv
// io_trap_capture: watches Z80 I/O bus cycles while virtualization is active,
// flags accesses to ports whose permission bit is clear, blocks the real
// device for the duration of the cycle and captures port/direction/write data
// for the trap handler.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   iorq_n/rd_n/wr_n/m1_n    raw asynchronous Z80 strobes
//   addr, data_in            Z80 A[7:0] and data bus (stable while iorq_n low)
//   virtual_enabled          virtualization active
//   trap_state               trap handler running (also gates mask writes)
//   cfg_we/cfg_sel/cfg_wdata permission mask byte write
//   rd_sel, rd_data          registered readback (port, data, status, mask byte)
//   cap_ack                  clears valid and overrun
//   io_violation, io_block   high while a violating I/O cycle is in progress
//   cap_valid                capture registers hold an unacknowledged violation
module io_trap_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MASK_RESET  = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       m1_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       virtual_enabled,
  input  logic       trap_state,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_wdata,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  input  logic       cap_ack,
  output logic       io_violation,
  output logic       io_block,
  output logic       cap_valid
);

  localparam int unsigned STROBES = 4;

  typedef enum logic [1:0] {
    S_WAIT_END,
    S_IDLE,
    S_PASS,
    S_TRAP
  } state_t;

  // Synchronizer stages; each entry holds {iorq, rd, wr, m1}
  logic [STROBES-1:0]     r_sync [SYNC_STAGES];
  // Fills with ones after reset so WAIT_END ignores the reset value of the chain
  logic [SYNC_STAGES-1:0] r_settle;
  logic                   r_iorq_prev;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_mask;
  logic [7:0]  r_port;
  logic [7:0]  r_data;
  logic [7:0]  r_pend;
  logic        r_dir;
  logic        r_valid;
  logic        r_overrun;
  logic        r_own;
  logic        r_violation;
  logic [7:0]  r_rd_data;

  logic       w_iorq_s;
  logic       w_rd_s;
  logic       w_wr_s;
  logic       w_m1_s;
  logic       w_start;
  logic       w_viol;
  logic       w_entry;
  logic       w_exit;
  logic       w_valid_ack;
  logic [4:0] w_mask_base;

  assign w_iorq_s = r_sync[SYNC_STAGES-1][3];
  assign w_rd_s   = r_sync[SYNC_STAGES-1][2];
  assign w_wr_s   = r_sync[SYNC_STAGES-1][1];
  assign w_m1_s   = r_sync[SYNC_STAGES-1][0];

  // Cycle start: synchronized IORQ falling edge outside interrupt acknowledge
  assign w_start     = r_iorq_prev & ~w_iorq_s & w_m1_s;
  assign w_viol      = virtual_enabled & ~trap_state & ~r_mask[addr[7:3]];
  assign w_entry     = (r_state == S_IDLE) & w_start & w_viol;
  assign w_exit      = (r_state == S_TRAP) & w_iorq_s;
  assign w_valid_ack = r_valid & ~cap_ack;
  assign w_mask_base = {cfg_sel, 3'b000};

  // Strobe synchronizers, reset to inactive
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '1;
      r_settle    <= '0;
      r_iorq_prev <= 1'b1;
    end else begin
      r_sync[0] <= {iorq_n, rd_n, wr_n, m1_n};
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      r_iorq_prev <= w_iorq_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT_END;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; the violation decision is taken once at cycle start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_END: if (w_iorq_s && r_settle[SYNC_STAGES-1]) w_state_nxt = S_IDLE;
      S_IDLE:     if (w_start) w_state_nxt = w_viol ? S_TRAP : S_PASS;
      S_PASS:     if (w_iorq_s) w_state_nxt = S_IDLE;
      S_TRAP:     if (w_iorq_s) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_WAIT_END;
    endcase
  end

  // Mask, capture registers, violation output and readback
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask      <= MASK_RESET;
      r_port      <= '0;
      r_data      <= '0;
      r_pend      <= '0;
      r_dir       <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_own       <= 1'b0;
      r_violation <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_violation <= (w_state_nxt == S_TRAP);

      if (cfg_we && trap_state) r_mask[w_mask_base +: 8] <= cfg_wdata;

      if (cap_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      // Ack is applied before a coincident capture via w_valid_ack
      if (w_entry) begin
        r_pend <= '0;
        if (!w_valid_ack) begin
          r_port    <= addr;
          r_dir     <= ~w_wr_s | w_rd_s;
          r_data    <= '0;
          r_valid   <= 1'b1;
          r_overrun <= 1'b0;
          r_own     <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
          r_own     <= 1'b0;
        end
      end

      if ((r_state == S_TRAP) && !w_wr_s) r_pend <= data_in;

      // Only the cycle that owns the capture publishes its write data
      if (w_exit) begin
        if (r_own) r_data <= r_pend;
        r_own <= 1'b0;
      end

      case (rd_sel)
        2'd0:    r_rd_data <= r_port;
        2'd1:    r_rd_data <= r_data;
        2'd2:    r_rd_data <= {5'b0, r_overrun, r_dir, r_valid};
        default: r_rd_data <= r_mask[w_mask_base +: 8];
      endcase
    end
  end

  assign io_violation = r_violation;
  assign io_block     = r_violation;
  assign cap_valid    = r_valid;
  assign rd_data      = r_rd_data;

endmodule

// File: tb/tb_io_trap_capture.sv
// Self-checking bench for io_trap_capture: directed scenarios followed by
// randomized I/O cycles, checked against a transaction-level reference model.
module tb_io_trap_capture;

  localparam logic [31:0] MASK_INIT = 32'h7FFF_FFFF;

  logic       clk;
  logic       rst;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] addr, data_in;
  logic       virtual_enabled, trap_state;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_wdata;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       cap_ack;
  logic       io_violation, io_block, cap_valid;

  io_trap_capture #(
    .SYNC_STAGES(2),
    .MASK_RESET (MASK_INIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .iorq_n         (iorq_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .m1_n           (m1_n),
    .addr           (addr),
    .data_in        (data_in),
    .virtual_enabled(virtual_enabled),
    .trap_state     (trap_state),
    .cfg_we         (cfg_we),
    .cfg_sel        (cfg_sel),
    .cfg_wdata      (cfg_wdata),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .cap_ack        (cap_ack),
    .io_violation   (io_violation),
    .io_block       (io_block),
    .cap_valid      (cap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_mask;
  logic        m_valid, m_overrun, m_dir;
  logic [7:0]  m_port, m_data;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mask    = MASK_INIT;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_dir     = 1'b0;
    m_port    = 8'h00;
    m_data    = 8'h00;
  endtask

  task automatic check_rb();
    logic [7:0] exp;
    for (int s = 0; s < 4; s++) begin
      rd_sel  = 2'(s);
      cfg_sel = 2'($urandom_range(0, 3));
      tick();
      case (s)
        0:       exp = m_port;
        1:       exp = m_data;
        2:       exp = {5'b0, m_overrun, m_dir, m_valid};
        default: exp = 8'((m_mask >> (8 * int'(cfg_sel))) & 32'hFF);
      endcase
      check_eq($sformatf("readback_sel%0d", s), rd_data, exp);
    end
    check_eq("cap_valid_idle", 8'(cap_valid), 8'(m_valid));
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] val, input logic ts);
    trap_state = ts;
    cfg_sel    = sel;
    cfg_wdata  = val;
    cfg_we     = 1'b1;
    tick();
    cfg_we     = 1'b0;
    trap_state = 1'b0;
    if (ts) m_mask[{sel, 3'b000} +: 8] = val;
  endtask

  task automatic do_ack();
    cap_ack = 1'b1;
    tick();
    cap_ack   = 1'b0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // One complete Z80 I/O (or interrupt acknowledge) cycle with timing checks
  task automatic io_cycle(input logic wr, input logic [7:0] port, input logic [7:0] d,
                          input logic intack, input logic ve, input logic ts,
                          input logic ack_entry, input int hold, input logic flip);
    logic v;
    logic own;
    virtual_enabled = ve;
    trap_state      = ts;
    addr            = port;
    data_in         = d;
    v = !intack && ve && !ts && (((m_mask >> (port / 8)) & 32'd1) == 32'd0);
    iorq_n = 1'b0;
    if (intack) m1_n = 1'b0;
    else if (wr) wr_n = 1'b0;
    else rd_n = 1'b0;
    tick();
    tick();
    check_eq("pre_rise", 8'({io_violation, io_block}), 8'h00);
    if (ack_entry) cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
    if (ack_entry) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
    own = 1'b0;
    if (v) begin
      if (!m_valid) begin
        m_port    = port;
        m_dir     = wr;
        m_data    = 8'h00;
        m_valid   = 1'b1;
        m_overrun = 1'b0;
        own       = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
    check_eq("rise", 8'({io_violation, io_block}), 8'({v, v}));
    check_eq("cap_valid_rise", 8'(cap_valid), 8'(m_valid));
    if (flip) begin
      virtual_enabled = ~ve;
      trap_state      = ~ts;
    end
    repeat (hold) tick();
    check_eq("hold", 8'({io_violation, io_block}), 8'({v, v}));
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
    tick();
    tick();
    check_eq("pre_fall", 8'({io_violation, io_block}), 8'({v, v}));
    tick();
    check_eq("fall", 8'({io_violation, io_block}), 8'h00);
    if (own && wr) m_data = d;
    trap_state = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    addr = 8'h00; data_in = 8'h00;
    virtual_enabled = 1'b0; trap_state = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = 8'h00;
    rd_sel = 2'd0; cap_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    check_eq("reset_outputs", 8'({io_violation, io_block, cap_valid}), 8'h00);
    check_eq("reset_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    repeat (3) tick();
    check_rb();

    // Allowed port with default mask
    io_cycle(1'b1, 8'h40, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    check_rb();

    // Handler blocks ports 0x40-0x47, then a violating OUT
    cfg_write(2'd1, 8'hFE, 1'b1);
    check_rb();
    io_cycle(1'b1, 8'h41, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    check_rb();

    // Second violation without ack sets overrun; ack clears
    io_cycle(1'b0, 8'h42, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    check_rb();
    do_ack();
    check_rb();

    // Exempt accesses and ignored mask write
    io_cycle(1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    io_cycle(1'b1, 8'h40, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    io_cycle(1'b1, 8'h40, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    cfg_write(2'd1, 8'h00, 1'b0);
    check_rb();

    // Reset in the middle of a trapped cycle; no re-trigger while IORQ stays low
    virtual_enabled = 1'b1;
    trap_state = 1'b0;
    addr = 8'hF9;
    data_in = 8'h11;
    iorq_n = 1'b0;
    wr_n = 1'b0;
    repeat (3) tick();
    check_eq("trap_before_reset", 8'(io_violation), 8'h01);
    rst = 1'b1;
    tick();
    check_eq("reset_mid_trap", 8'({io_violation, io_block, cap_valid}), 8'h00);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("no_retrigger", 8'({io_violation, io_block}), 8'h00);
    end
    iorq_n = 1'b1;
    wr_n = 1'b1;
    repeat (4) tick();
    check_rb();
    io_cycle(1'b1, 8'hF8, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    check_rb();

    // Ack coincident with a new capture
    cfg_write(2'd1, 8'hE0, 1'b1);
    io_cycle(1'b1, 8'h44, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    check_rb();
    do_ack();

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        cfg_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end else if (op == 1) begin
        do_ack();
      end else begin
        io_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      check_rb();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
